linear_sequencer: RTL and testbench



---
 rtl/linear_sequencer_if.sv | 20 ++
 rtl/linear_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_linear_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/linear_sequencer_if.sv
// Wishbone classic read bus between the layer sequencer (master) and the weight SRAM (slave).
interface linear_sequencer_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
      output wbm_ack_i, wbm_dat_i
   );
endinterface

// File: rtl/linear_sequencer.sv
// Fully-connected layer sequencer: fetches each weight over Wishbone, multiply-accumulates in
// saturating Q8.24 and emits one result per output neuron.
module linear_sequencer #(
   parameter int IN_DIM  = 20,
   parameter int OUT_DIM = 3,
   parameter int W_BASE  = 0,
   parameter int FRAC    = 24,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [9:0]          in_rd_addr,
   input  logic signed [31:0]  in_rd_data,
   linear_sequencer_if.master  wb,
   output logic                out_valid,
   output logic [9:0]          out_addr,
   output logic signed [31:0]  out_data
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [9:0]    I_LAST = 10'(IN_DIM - 1);
   localparam logic [9:0]    J_LAST = 10'(OUT_DIM - 1);
   localparam logic signed [63:0] MAX_V = 64'sd2147483647;
   localparam logic signed [63:0] MIN_V = -64'sd2147483648;

   typedef enum logic [2:0] {IDLE, RD_IN, WB, MAC, EMIT, DONE} state_t;

   state_t             state;
   logic [9:0]         i;
   logic [9:0]         j;
   logic [TW-1:0]      tcnt;
   logic               first_wb;
   logic signed [31:0] acc;
   logic signed [31:0] acc_next;
   logic signed [31:0] x_reg;
   logic signed [31:0] w_reg;
   logic               cyc;
   logic               stb;
   logic [3:0]         sel;
   logic [31:0]        adr;

   // Product rescaled to Q8.24, clamped instead of wrapping when it leaves the 32-bit range.
   function automatic logic signed [31:0] sat_term(input logic signed [63:0] prod);
      logic signed [63:0] sh;
      sh = prod >>> FRAC;
      if (sh > MAX_V)
         return 32'sh7FFFFFFF;
      else if (sh < MIN_V)
         return 32'sh80000000;
      else
         return sh[31:0];
   endfunction

   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
      logic signed [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31])
         return s[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
      else
         return s[31:0];
   endfunction

   function automatic logic [31:0] byte_addr(input logic [9:0] jj, input logic [9:0] ii);
      logic [31:0] word;
      word = 32'(W_BASE) + 32'(jj) * 32'(IN_DIM) + 32'(ii);
      return word << 2;
   endfunction

   always_comb begin
      acc_next = sat_add(acc, sat_term(64'(x_reg) * 64'(w_reg)));
   end

   assign wb.wbm_cyc_o = cyc;
   assign wb.wbm_stb_o = stb;
   assign wb.wbm_we_o  = 1'b0;
   assign wb.wbm_sel_o = sel;
   assign wb.wbm_adr_o = adr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         i          <= '0;
         j          <= '0;
         tcnt       <= '0;
         first_wb   <= 1'b0;
         acc        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cyc        <= 1'b0;
         stb        <= 1'b0;
         sel        <= '0;
         adr        <= '0;
         in_rd_addr <= '0;
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               busy <= start;
               if (start) begin
                  state      <= RD_IN;
                  i          <= '0;
                  j          <= '0;
                  acc        <= '0;
                  in_rd_addr <= '0;
               end
            end
            RD_IN: begin
               state    <= WB;
               cyc      <= 1'b1;
               stb      <= 1'b1;
               sel      <= 4'hF;
               adr      <= byte_addr(j, i);
               tcnt     <= '0;
               first_wb <= 1'b1;
            end
            WB: begin
               // The activation read issued in RD_IN is valid during the first bus cycle only.
               first_wb <= 1'b0;
               if (first_wb)
                  x_reg <= in_rd_data;
               if (wb.wbm_ack_i) begin
                  w_reg <= wb.wbm_dat_i;
                  cyc   <= 1'b0;
                  stb   <= 1'b0;
                  sel   <= '0;
                  state <= MAC;
               end else if (tcnt == T_LAST) begin
                  cyc   <= 1'b0;
                  stb   <= 1'b0;
                  sel   <= '0;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            MAC: begin
               acc <= acc_next;
               if (i == I_LAST) begin
                  state <= EMIT;
               end else begin
                  i          <= i + 1'b1;
                  in_rd_addr <= i + 1'b1;
                  state      <= RD_IN;
               end
            end
            EMIT: begin
               out_valid <= 1'b1;
               out_addr  <= j;
               out_data  <= acc;
               acc       <= '0;
               i         <= '0;
               if (j == J_LAST) begin
                  state <= DONE;
               end else begin
                  j          <= j + 1'b1;
                  in_rd_addr <= '0;
                  state      <= RD_IN;
               end
            end
            DONE: begin
               // busy is left high through the done cycle and drops from IDLE on the next edge.
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_linear_sequencer.sv
// Directed bench for linear_sequencer: arithmetic reference model, Wishbone SRAM with wait states,
// per-cycle output monitor.
module tb_linear_sequencer;
   localparam int IN  = 4;
   localparam int OUT = 2;
   localparam int TO  = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               busy, done, err, out_valid;
   logic [9:0]         in_rd_addr, out_addr;
   logic signed [31:0] in_rd_data;
   logic signed [31:0] out_data;

   linear_sequencer_if wb();

   linear_sequencer #(.IN_DIM(IN), .OUT_DIM(OUT), .W_BASE(0), .FRAC(24), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data), .wb(wb),
      .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
   );

   always #5 clk = ~clk;

   logic [31:0] in_mem [IN];
   logic [31:0] w_mem  [IN*OUT];
   int wait_n = 0;
   bit noack = 1'b0;
   int wcnt = 0;
   int cyc_n = 0;

   // Input buffer (1-cycle synchronous read) and weight SRAM with wait_n wait states.
   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      in_rd_data <= in_mem[in_rd_addr[1:0]];
      if (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end
   assign wb.wbm_ack_i = wb.wbm_cyc_o && wb.wbm_stb_o && !noack && (wcnt == wait_n);
   assign wb.wbm_dat_i = w_mem[wb.wbm_adr_o[4:2]];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic longint clamp(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic logic [31:0] model_row(input int jj);
      longint acc, p;
      acc = 0;
      for (int k = 0; k < IN; k++) begin
         p = longint'($signed(in_mem[k])) * longint'($signed(w_mem[jj*IN + k]));
         p = clamp(p >>> 24);
         acc = clamp(acc + p);
      end
      return acc[31:0];
   endfunction

   typedef struct { logic [9:0] a; logic [31:0] d; } res_t;
   typedef struct { logic [31:0] adr; logic [9:0] i; } acc_t;
   res_t exp_q[$];
   acc_t adr_q[$];

   bit mon_on = 1'b0, expect_done = 1'b0, expect_err = 1'b0;
   bit done_seen, err_seen;
   int start_cyc = 0, n_out = 0, mac_per = 3;
   logic [9:0]  hold_a = '0;
   logic [31:0] hold_d = '0;
   logic        prev_stb = 1'b0;
   logic [31:0] prev_adr = '0;
   logic [31:0] got_d [2];

   always @(negedge clk) begin : monitor
      int el;
      res_t e;
      acc_t a;
      if (mon_on) begin
         el = cyc_n - start_cyc;
         if (out_valid) begin
            n_out++;
            if (exp_q.size() == 0) chk("unexpected out_valid", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_addr", out_addr, e.a);
               chk("out_data", out_data, e.d);
               chk("emit latency", el, n_out * (IN * mac_per + 1));
               hold_a = e.a;
               hold_d = e.d;
               if (n_out <= 2) got_d[n_out-1] = out_data;
            end
         end else begin
            chk("out_addr hold", out_addr, hold_a);
            chk("out_data hold", out_data, hold_d);
         end
         if (done) begin
            done_seen = 1'b1;
            if (!expect_done) chk("unexpected done", 1, 0);
            else begin
               chk("done latency", el, OUT * (IN * mac_per + 1) + 1);
               chk("results left at done", exp_q.size(), 0);
               chk("busy during done", busy, 1);
            end
         end
         if (err) begin
            err_seen = 1'b1;
            if (!expect_err) chk("unexpected err", 1, 0);
            else begin
               chk("err latency", el, TO + 1);
               chk("cyc at err", wb.wbm_cyc_o, 0);
               chk("stb at err", wb.wbm_stb_o, 0);
               chk("busy at err", busy, 0);
            end
         end
         chk("cyc equals stb", wb.wbm_cyc_o, wb.wbm_stb_o);
         chk("we low", wb.wbm_we_o, 0);
         chk("sel", wb.wbm_sel_o, wb.wbm_stb_o ? 32'hF : 32'h0);
         if (wb.wbm_stb_o && !prev_stb) begin
            if (adr_q.size() == 0) chk("unexpected access", 1, 0);
            else begin
               a = adr_q.pop_front();
               chk("wbm_adr_o", wb.wbm_adr_o, a.adr);
               chk("in_rd_addr", in_rd_addr, a.i);
            end
         end
         if (wb.wbm_stb_o && prev_stb) chk("adr stable", wb.wbm_adr_o, prev_adr);
         prev_stb = wb.wbm_stb_o;
         prev_adr = wb.wbm_adr_o;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " err"}, err, 0);
      chk({tag, " cyc"}, wb.wbm_cyc_o, 0);
      chk({tag, " stb"}, wb.wbm_stb_o, 0);
      chk({tag, " we"}, wb.wbm_we_o, 0);
      chk({tag, " sel"}, wb.wbm_sel_o, 0);
      chk({tag, " adr"}, wb.wbm_adr_o, 0);
      chk({tag, " in_rd_addr"}, in_rd_addr, 0);
      chk({tag, " out_valid"}, out_valid, 0);
      chk({tag, " out_addr"}, out_addr, 0);
      chk({tag, " out_data"}, out_data, 0);
   endtask

   task automatic load(input logic [31:0] x, input logic [31:0] w0, input logic [31:0] w1);
      for (int k = 0; k < IN; k++) begin
         in_mem[k] = x;
         w_mem[k] = w0;
         w_mem[IN + k] = w1;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      start_cyc = cyc_n;
   endtask

   task automatic run(input int w, input bit mid_start);
      wait_n = w;
      mac_per = 3 + w;
      n_out = 0;
      done_seen = 1'b0;
      expect_done = 1'b1;
      expect_err = 1'b0;
      for (int jj = 0; jj < OUT; jj++) begin
         exp_q.push_back('{10'(jj), model_row(jj)});
         for (int ii = 0; ii < IN; ii++) adr_q.push_back('{32'((jj*IN + ii) * 4), 10'(ii)});
      end
      pulse_start();
      if (mid_start) begin
         repeat (5) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int k = 0; k < 400 && !done_seen; k++) @(negedge clk);
      if (!done_seen) chk("done within budget", 0, 1);
      chk("accesses left", adr_q.size(), 0);
      repeat (2) @(negedge clk);
      chk("busy after done", busy, 0);
      expect_done = 1'b0;
      exp_q.delete();
      adr_q.delete();
   endtask

   initial begin
      load(32'h01000000, 32'h00800000, 32'hFF000000);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      mon_on = 1'b1;

      // Scenario 1/2: basic layer and address walk.
      chk("model row0", model_row(0), 32'h02000000);
      chk("model row1", model_row(1), 32'hFC000000);
      run(0, 1'b0);
      chk("s1 out0", got_d[0], 32'h02000000);
      chk("s1 out1", got_d[1], 32'hFC000000);

      // Scenario 3: saturation both directions.
      load(32'h64000000, 32'h64000000, 32'h64000000);
      chk("model sat pos", model_row(0), 32'h7FFFFFFF);
      run(0, 1'b0);
      chk("sat pos out0", got_d[0], 32'h7FFFFFFF);
      chk("sat pos out1", got_d[1], 32'h7FFFFFFF);
      load(32'h64000000, 32'h9C000000, 32'h9C000000);
      chk("model sat neg", model_row(1), 32'h80000000);
      run(0, 1'b0);
      chk("sat neg out0", got_d[0], 32'h80000000);
      chk("sat neg out1", got_d[1], 32'h80000000);

      // Scenario 4: three wait states per access.
      load(32'h01000000, 32'h00800000, 32'hFF000000);
      run(3, 1'b0);
      chk("ws out0", got_d[0], 32'h02000000);
      chk("ws out1", got_d[1], 32'hFC000000);

      // Scenario 5: ack never arrives.
      noack = 1'b1;
      wait_n = 0;
      expect_err = 1'b1;
      err_seen = 1'b0;
      adr_q.push_back('{32'h0, 10'd0});
      pulse_start();
      for (int k = 0; k < 50 && !err_seen; k++) @(negedge clk);
      if (!err_seen) chk("err within budget", 0, 1);
      repeat (10) @(negedge clk);
      chk("busy after timeout", busy, 0);
      chk("timeout accesses left", adr_q.size(), 0);
      noack = 1'b0;
      expect_err = 1'b0;
      adr_q.delete();
      run(0, 1'b0);
      chk("after timeout out0", got_d[0], 32'h02000000);
      chk("after timeout out1", got_d[1], 32'hFC000000);

      // Scenario 6: reset during the second WB cycle, then a rerun with a stray start while busy.
      mon_on = 1'b0;
      wait_n = 3;
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      chk("stb before reset", wb.wbm_stb_o, 1);
      chk("busy before reset", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid reset");
      rst_n = 1'b1;
      hold_a = '0;
      hold_d = '0;
      prev_stb = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle after reset busy", busy, 0);
      chk("idle after reset cyc", wb.wbm_cyc_o, 0);
      mon_on = 1'b1;
      run(0, 1'b1);
      chk("rerun out0", got_d[0], 32'h02000000);
      chk("rerun out1", got_d[1], 32'hFC000000);

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
